// File: rtl/dmem_pkg.sv
// Shared encodings and the byte-enable helper for the byte-lane data memory.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    // Misaligned halves shift bits off the top; those requests are rejected upstream anyway.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_B:  byte_mask = 4'b0001 << offset;
            SIZE_H:  byte_mask = 4'b0011 << offset;
            SIZE_W:  byte_mask = 4'b1111;
            default: byte_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// Request/response bundle between the load/store unit and the data memory.
interface data_memory_bytelane_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        init_busy;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, init_busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, init_busy
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store-data replication with byte enables,
// and load-data right-justification with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wlanes,
    output logic [3:0]  byte_en,
    output logic [31:0] rdata
);

    logic [15:0] shifted;
    logic        fill;

    always_comb begin
        shifted = 16'(rword >> {offset, 3'b000});
        wlanes  = wdata;
        rdata   = rword;
        fill    = 1'b0;
        byte_en = byte_mask(size, offset);
        case (size)
            SIZE_B: begin
                wlanes = {4{wdata[7:0]}};
                fill   = ~is_unsigned & shifted[7];
                rdata  = {{24{fill}}, shifted[7:0]};
            end
            SIZE_H: begin
                wlanes = {2{wdata[15:0]}};
                fill   = ~is_unsigned & shifted[15];
                rdata  = {{16{fill}}, shifted};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressable data memory: post-reset clear sequencer, range/alignment
// checks, byte-lane stores and registered one-cycle responses.
module data_memory_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter bit INIT_ZERO = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    data_memory_bytelane_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] init_idx;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    offset;
    logic          out_of_range, misaligned, bad_size, err, accept;
    logic [31:0]   wlanes, rdata;
    logic [3:0]    byte_en;

    assign idx          = bus.req_addr[2 +: AW];
    assign offset       = bus.req_addr[1:0];
    assign out_of_range = |bus.req_addr[31:AW+2];
    assign misaligned   = (bus.req_size == SIZE_H && bus.req_addr[0]) ||
                          (bus.req_size == SIZE_W && offset != 2'b00);
    assign bad_size     = (bus.req_size == 2'b11);
    assign err          = out_of_range | misaligned | bad_size;
    assign accept       = bus.req_valid & bus.req_ready;

    dmem_lane_align u_align (
        .size        (bus.req_size),
        .offset      (offset),
        .is_unsigned (bus.req_unsigned),
        .wdata       (bus.req_wdata),
        .rword       (mem[idx]),
        .wlanes      (wlanes),
        .byte_en     (byte_en),
        .rdata       (rdata)
    );

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.init_busy = 1'b0;
        case (state)
            ST_INIT: begin
                bus.init_busy = 1'b1;
                if (init_idx == AW'(DEPTH - 1))
                    state_nxt = ST_IDLE;
            end
            ST_IDLE: bus.req_ready = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT_ZERO ? ST_INIT : ST_IDLE;
            init_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)
                init_idx <= init_idx + 1'b1;
        end
    end

    // Reset on the same edge as a store suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                mem[init_idx] <= '0;
            end else if (accept && bus.req_write && !err) begin
                for (int b = 0; b < 4; b++)
                    if (byte_en[b])
                        mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_error <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= accept;
            bus.rsp_error <= accept & err;
            bus.rsp_rdata <= (accept && !err && !bus.req_write) ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Scoreboard bench for data_memory_bytelane (DEPTH=64, INIT_ZERO=1).
module tb_data_memory_bytelane;
    import dmem_pkg::*;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    data_memory_bytelane_if bus();

    data_memory_bytelane #(.DEPTH(64), .INIT_ZERO(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic req_t mk(input logic w, input logic [31:0] a, input logic [1:0] s,
                                input logic u, input logic [31:0] d);
        req_t r;
        r.write = w; r.addr = a; r.size = s; r.uns = u; r.wdata = d;
        return r;
    endfunction

    function automatic exp_t mx(input logic [31:0] rd, input logic er);
        exp_t e;
        e.rdata = rd; e.error = er;
        return e;
    endfunction

    task automatic drive(input req_t r, input exp_t e);
        bus.req_valid    = 1'b1;
        bus.req_write    = r.write;
        bus.req_addr     = r.addr;
        bus.req_size     = r.size;
        bus.req_unsigned = r.uns;
        bus.req_wdata    = r.wdata;
        sb.push_back(e);
    endtask

    task automatic idle_bus();
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = SIZE_W;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;
    endtask

    task automatic test_reset();
        int cnt;
        bit ready_seen;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp valid=%b rdata=%h err=%b required 0/0/0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_error);
        end
        checks++;
        if (bus.init_busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b ready=%b required busy=1 ready=0",
                     bus.init_busy, bus.req_ready);
        end
        // a store held during the clear must be ignored
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h10;
        bus.req_size = SIZE_W; bus.req_wdata = 32'hDEAD_BEEF;
        reset = 1'b0;
        cnt = 0; ready_seen = 1'b0;
        while (cnt < 200 && !ready_seen) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.req_ready === 1'b1) begin
                ready_seen = 1'b1;
                idle_bus();
            end else begin
                checks++;
                if (bus.init_busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL init_cycle%0d busy=%b rsp_valid=%b required busy=1 rsp_valid=0",
                             cnt, bus.init_busy, bus.rsp_valid);
                end
            end
        end
        checks++;
        if (!ready_seen || cnt != 64) begin
            errors++;
            $display("FAIL init_length cycles=%0d ready_seen=%b required 64", cnt, ready_seen);
        end
        checks++;
        if (bus.init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_done busy=%b required 0", bus.init_busy);
        end
    endtask

    task automatic test_clear_readback();
        req_t rq[$];
        exp_t ex[$];
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            rq.push_back(mk(1'b0, 32'(i * 4), SIZE_W, 1'b0, 32'h0));
            ex.push_back(mx(32'h0, 1'b0));
        end
        foreach (rq[i]) begin
            drive(rq[i], ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_error !== e.error) begin
                errors++;
                $display("FAIL clear[%0d] valid=%b rdata=%h err=%b required valid=1 rdata=%h err=%b",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, e.rdata, e.error);
            end
        end
        idle_bus();
    endtask

    task automatic test_extend();
        req_t rq[$];
        exp_t ex[$];
        exp_t e;
        rq.push_back(mk(1'b1, 32'h10, SIZE_W, 1'b0, 32'h8001_7FFF)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b0, 32'h10, SIZE_B, 1'b0, 32'h0)); ex.push_back(mx(32'hFFFF_FFFF, 1'b0));
        rq.push_back(mk(1'b0, 32'h11, SIZE_B, 1'b1, 32'h0)); ex.push_back(mx(32'h0000_007F, 1'b0));
        rq.push_back(mk(1'b0, 32'h12, SIZE_H, 1'b0, 32'h0)); ex.push_back(mx(32'hFFFF_8001, 1'b0));
        rq.push_back(mk(1'b0, 32'h12, SIZE_H, 1'b1, 32'h0)); ex.push_back(mx(32'h0000_8001, 1'b0));
        rq.push_back(mk(1'b0, 32'h10, SIZE_H, 1'b0, 32'h0)); ex.push_back(mx(32'h0000_7FFF, 1'b0));
        rq.push_back(mk(1'b0, 32'h13, SIZE_B, 1'b0, 32'h0)); ex.push_back(mx(32'hFFFF_FF80, 1'b0));
        rq.push_back(mk(1'b0, 32'h10, SIZE_W, 1'b1, 32'h0)); ex.push_back(mx(32'h8001_7FFF, 1'b0));
        foreach (rq[i]) begin
            drive(rq[i], ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_error !== e.error) begin
                errors++;
                $display("FAIL extend[%0d] valid=%b rdata=%h err=%b required valid=1 rdata=%h err=%b",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, e.rdata, e.error);
            end
        end
        idle_bus();
    endtask

    task automatic test_byte_store();
        req_t rq[$];
        exp_t ex[$];
        exp_t e;
        rq.push_back(mk(1'b1, 32'h20, SIZE_W, 1'b0, 32'h1122_3344)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b1, 32'h21, SIZE_B, 1'b0, 32'hFFFF_FFAB)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b0, 32'h20, SIZE_W, 1'b0, 32'h0));         ex.push_back(mx(32'h1122_AB44, 1'b0));
        rq.push_back(mk(1'b1, 32'h22, SIZE_H, 1'b0, 32'h1234_BEEF)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b0, 32'h20, SIZE_W, 1'b0, 32'h0));         ex.push_back(mx(32'hBEEF_AB44, 1'b0));
        foreach (rq[i]) begin
            drive(rq[i], ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_error !== e.error) begin
                errors++;
                $display("FAIL byte_store[%0d] valid=%b rdata=%h err=%b required valid=1 rdata=%h err=%b",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, e.rdata, e.error);
            end
        end
        idle_bus();
    endtask

    task automatic test_errors();
        req_t rq[$];
        exp_t ex[$];
        exp_t e;
        rq.push_back(mk(1'b1, 32'h00, SIZE_W, 1'b0, 32'hCAFE_F00D)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b0, 32'h02, SIZE_W, 1'b0, 32'h0));         ex.push_back(mx(32'h0, 1'b1));
        rq.push_back(mk(1'b1, 32'h03, SIZE_H, 1'b0, 32'h0000_FFFF)); ex.push_back(mx(32'h0, 1'b1));
        rq.push_back(mk(1'b1, 32'h00, 2'b11,  1'b0, 32'h0));         ex.push_back(mx(32'h0, 1'b1));
        rq.push_back(mk(1'b1, 32'h100, SIZE_W, 1'b0, 32'h0));        ex.push_back(mx(32'h0, 1'b1));
        rq.push_back(mk(1'b0, 32'h100, SIZE_W, 1'b0, 32'h0));        ex.push_back(mx(32'h0, 1'b1));
        rq.push_back(mk(1'b1, 32'h05, SIZE_W, 1'b0, 32'h0));         ex.push_back(mx(32'h0, 1'b1));
        rq.push_back(mk(1'b0, 32'h01, SIZE_H, 1'b1, 32'h0));         ex.push_back(mx(32'h0, 1'b1));
        rq.push_back(mk(1'b0, 32'hFFFF_FFFC, SIZE_W, 1'b0, 32'h0));  ex.push_back(mx(32'h0, 1'b1));
        rq.push_back(mk(1'b0, 32'h00, SIZE_W, 1'b0, 32'h0));         ex.push_back(mx(32'hCAFE_F00D, 1'b0));
        rq.push_back(mk(1'b0, 32'hFC, SIZE_W, 1'b0, 32'h0));         ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b1, 32'hFF, SIZE_B, 1'b0, 32'h0000_005A)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b0, 32'hFF, SIZE_B, 1'b0, 32'h0));         ex.push_back(mx(32'h0000_005A, 1'b0));
        rq.push_back(mk(1'b0, 32'hFC, SIZE_W, 1'b0, 32'h0));         ex.push_back(mx(32'h5A00_0000, 1'b0));
        foreach (rq[i]) begin
            drive(rq[i], ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_error !== e.error) begin
                errors++;
                $display("FAIL errors[%0d] valid=%b rdata=%h err=%b required valid=1 rdata=%h err=%b",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, e.rdata, e.error);
            end
        end
        idle_bus();
    endtask

    task automatic test_back_to_back();
        req_t rq[$];
        exp_t ex[$];
        exp_t e;
        rq.push_back(mk(1'b1, 32'h08, SIZE_W, 1'b0, 32'h0000_0005)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b0, 32'h08, SIZE_W, 1'b0, 32'h0));         ex.push_back(mx(32'h0000_0005, 1'b0));
        foreach (rq[i]) begin
            drive(rq[i], ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_error !== e.error) begin
                errors++;
                $display("FAIL b2b[%0d] valid=%b rdata=%h err=%b required valid=1 rdata=%h err=%b",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, e.rdata, e.error);
            end
        end
        idle_bus();
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse rsp_valid=%b required 0", bus.rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        req_t rq[$];
        exp_t ex[$];
        exp_t e;
        int   cnt;
        bit   ready_seen;
        // store coinciding with reset: no response, no write, clear restarts
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h30;
        bus.req_size = SIZE_W; bus.req_wdata = 32'h0000_0077;
        reset = 1'b1;
        @(posedge clk); #1;
        idle_bus();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.init_busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_store rsp_valid=%b busy=%b ready=%b required 0/1/0",
                     bus.rsp_valid, bus.init_busy, bus.req_ready);
        end
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cnt = 0; ready_seen = 1'b0;
        while (cnt < 200 && !ready_seen) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.req_ready === 1'b1) ready_seen = 1'b1;
        end
        checks++;
        if (!ready_seen || cnt != 64) begin
            errors++;
            $display("FAIL reinit_length cycles=%0d ready_seen=%b required 64", cnt, ready_seen);
        end
        rq.push_back(mk(1'b0, 32'h30, SIZE_W, 1'b0, 32'h0)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b0, 32'h20, SIZE_W, 1'b0, 32'h0)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b0, 32'h00, SIZE_W, 1'b0, 32'h0)); ex.push_back(mx(32'h0, 1'b0));
        rq.push_back(mk(1'b0, 32'hFC, SIZE_W, 1'b0, 32'h0)); ex.push_back(mx(32'h0, 1'b0));
        foreach (rq[i]) begin
            drive(rq[i], ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_error !== e.error) begin
                errors++;
                $display("FAIL reinit_read[%0d] valid=%b rdata=%h err=%b required valid=1 rdata=%h err=%b",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, e.rdata, e.error);
            end
        end
        idle_bus();
    endtask

    initial begin
        idle_bus();
        reset = 1'b1;
        test_reset();
        test_clear_readback();
        test_extend();
        test_byte_store();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_memory_bytelane.md
# data_memory_bytelane

Parametrised byte-addressable data memory for the RISC-V core's load/store path. It supports LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane enables, sign and zero extension, and misalignment and range checking. Requests use a valid/ready handshake, and every response is registered. After reset, a built-in sequencer clears the array one word per cycle. It replaces the flat word-indexed memory between the ALU address output and the write-back mux.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; power of two, ≥ 2.
- INIT_ZERO, 1: 1 = clear the array after reset; 0 = skip clearing (contents undefined).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  memory can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, taken from the low bytes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_error  out  1  request was misaligned, out of range, or used size 11.
- init_busy  out  1  clearing in progress.

## Operation
- States:
  - INIT: clear sequence running.
  - IDLE: normal service.
- Reset entry:
  - With INIT_ZERO=1, reset sends the block to INIT.
  - With INIT_ZERO=0, reset sends the block to IDLE.
- INIT:
  - Counter init_idx is cleared by reset.
  - Each cycle, word init_idx is written with 0 and init_idx increments.
  - When init_idx = DEPTH-1 is written, the state moves to IDLE.
  - req_ready=0 and init_busy=1 throughout INIT.
- IDLE: req_ready=1 and init_busy=0.
- A request is accepted when req_valid && req_ready. A single request can be accepted every cycle; there is no response backpressure.
- Addressing:
  - Word index = req_addr[2 +: log2(DEPTH)].
  - Byte offset = req_addr[1:0].
- Error conditions: any one of the following raises rsp_error=1 and rsp_rdata=0, with no array write:
  - req_addr ≥ 4*DEPTH.
  - Half access with req_addr[0]=1.
  - Word access with req_addr[1:0]≠0.
  - req_size=11.
- Stores:
  - Byte: lane = offset, data = wdata[7:0].
  - Half: lanes offset and offset+1, data = wdata[15:0].
  - Word: all four lanes.
  - Lanes not enabled keep their old contents.
  - A store produces rsp_valid with rsp_rdata=0.
- Loads:
  - Selected bytes are right-justified.
  - Bits above the access size are filled from the top bit of the selected data (sign) or with 0 (req_unsigned=1).
  - Word loads ignore req_unsigned.
- A request presented while req_ready=0 is ignored and produces no response.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_error=0, init_idx=0. With INIT_ZERO=1, also init_busy=1 and req_ready=0.
- Clear duration with INIT_ZERO=1: after reset deasserts, exactly DEPTH rising edges complete the clear. req_ready rises in the cycle after the DEPTH-th edge.
- Latency is 1 cycle for every request type. A request accepted at edge N produces rsp_valid=1 in the cycle after edge N; the response is held for exactly one cycle unless another request is accepted at edge N+1.
- Store data is visible to a load accepted on the next edge (back-to-back SW then LW returns the new value).
- Reset asserted mid-operation (INIT or IDLE) takes effect at the next edge:
  - Any in-flight response is dropped (rsp_valid=0).
  - A pending store on that edge is not performed.
  - The clear restarts from word 0.

## Structure
- Package dmem_pkg holds:
  - Size encodings SIZE_B, SIZE_H, SIZE_W.
  - State enum {ST_INIT, ST_IDLE}.
  - A function returning the 4-bit byte-enable mask for (size, offset).
- Sub-module dmem_lane_align (combinational) provides:
  - Store-lane replication and byte-enable generation.
  - Load-lane extraction and extension.
- The top level holds the array, FSM, init counter and response registers.

## Test plan
- Reset, DEPTH=64: init_busy stays high for 64 cycles and req_ready is low throughout; LW of every address afterwards returns 0.
- SW 0x8001_7FFF at address 0x10, then LB@0x10 → 0xFFFF_FFFF, LBU@0x11 → 0x0000_007F, LH@0x12 → 0xFFFF_8001, LHU@0x12 → 0x0000_8001.
- SB 0xAB at address 0x21 over word 0x1122_3344 at 0x20 → LW@0x20 returns 0x1122_AB44 on the cycle after the load is accepted.
- LW@0x02, SH@0x03, size 11, and LW@0x100 (DEPTH=64) each → rsp_error=1 and rsp_rdata=0; the array is unchanged.
- Back-to-back: SW 0x5 @0x8, then LW@0x8 on the next edge → rsp_valid on two consecutive cycles, with the second returning 0x5.
- Assert reset during a store and also mid-INIT → the store is not performed, the clear restarts from word 0, rsp_valid=0, and the full DEPTH-cycle init runs again.
